// File: rtl/sa_pkg.sv
// Shared definitions for the systolic matrix-multiply engine:
// FSM state encoding and the saturating-accumulate helper.
package sa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Wide working type for saturation; holds any supported AW plus headroom.
    localparam int unsigned SAT_W = 128;
    typedef logic signed [SAT_W-1:0] sat_t;

    // acc + prod clamped to the signed range of an aw-bit accumulator.
    function automatic sat_t sat_add(input sat_t acc, input sat_t prod, input int unsigned aw);
        sat_t sum;
        sat_t hi;
        sat_t lo;
        sum = acc + prod;
        hi  = (sat_t'(1) <<< (aw - 1)) - sat_t'(1);
        lo  = -(sat_t'(1) <<< (aw - 1));
        if (sum > hi) begin
            sat_add = hi;
        end else if (sum < lo) begin
            sat_add = lo;
        end else begin
            sat_add = sum;
        end
    endfunction

endpackage

// File: rtl/sa_pe.sv
// Processing element: one output-stationary MAC plus A (rightward) and
// B (downward) forwarding registers. Optional macro SA_SATURATE_EN selects
// saturating accumulation instead of wrap-around.
// Ports: clk, rst_n (async active-low), clr (sync clear), adv (advance),
//        a_in/b_in operands, a_out/b_out forwarded operands, acc result.
module sa_pe
    import sa_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 adv,
    input  logic signed [DW-1:0] a_in,
    input  logic signed [DW-1:0] b_in,
    output logic signed [DW-1:0] a_out,
    output logic signed [DW-1:0] b_out,
    output logic signed [AW-1:0] acc
);

    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   prod_ext;

    assign prod     = (2*DW)'(a_in) * (2*DW)'(b_in);
    assign prod_ext = AW'(prod);

    // MAC and operand forwarding; everything holds unless advanced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (adv) begin
            a_out <= a_in;
            b_out <= b_in;
`ifdef SA_SATURATE_EN
            acc   <= AW'(sat_add(SAT_W'(acc), SAT_W'(prod_ext), AW));
`else
            acc   <= acc + prod_ext;
`endif
        end
    end

endmodule

// File: rtl/sa_matmul_engine.sv
// Output-stationary ROWS x COLS systolic array computing C = A * B.
// A columns enter from the left, B rows from the top, both skewed so that
// PE(i,j) sees A[i][k] and B[k][j] on the same advance. Results drain one
// row of C per c_valid/c_ready beat.
// Optional macro SA_SATURATE_EN: saturating accumulation (default wraps).
// Ports: clk, rst_n; start/k_len job control; busy/done status;
//        a_valid/a_ready/a_data A column; b_valid/b_ready/b_data B row;
//        c_valid/c_ready/c_data/c_row result rows.
module sa_matmul_engine
    import sa_pkg::*;
#(
    parameter int unsigned DW   = 16,
    parameter int unsigned AW   = 40,
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [15:0]               k_len,
    output logic                      busy,
    output logic                      done,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [ROWS*DW-1:0]        a_data,
    input  logic                      b_valid,
    output logic                      b_ready,
    input  logic [COLS*DW-1:0]        b_data,
    output logic                      c_valid,
    input  logic                      c_ready,
    output logic [COLS*AW-1:0]        c_data,
    output logic [$clog2(ROWS)-1:0]   c_row
);

    localparam int unsigned RW        = $clog2(ROWS);
    localparam int unsigned FLUSH_LEN = ROWS + COLS - 1;
    localparam int unsigned FW        = $clog2(FLUSH_LEN + 1);

    state_t          state;
    logic [15:0]     k_reg;
    logic [15:0]     fire_cnt;
    logic [FW-1:0]   flush_cnt;

    logic            fire;
    logic            adv;
    logic            clr;

    logic signed [DW-1:0] a_edge [ROWS];
    logic signed [DW-1:0] b_edge [COLS];
    logic signed [DW-1:0] a_fw   [ROWS][COLS];
    logic signed [DW-1:0] b_fw   [ROWS][COLS];
    logic signed [AW-1:0] accs   [ROWS][COLS];

    logic [RW-1:0]        load_row;
    logic [COLS*AW-1:0]   row_vec;

    assign fire = (state == ST_FEED) & a_valid & b_valid;
    assign adv  = fire | (state == ST_FLUSH);
    assign clr  = (state == ST_IDLE) & start;

    // A skew: row i passes through i registers; zeros are injected outside FEED.
    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        logic signed [DW-1:0] a_src;
        assign a_src = (state == ST_FEED) ? $signed(a_data[i*DW +: DW]) : '0;
        if (i == 0) begin : g_direct
            assign a_edge[i] = a_src;
        end else begin : g_line
            logic signed [DW-1:0] line [i];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int n = 0; n < i; n++) line[n] <= '0;
                end else if (clr) begin
                    for (int n = 0; n < i; n++) line[n] <= '0;
                end else if (adv) begin
                    line[0] <= a_src;
                    for (int n = 1; n < i; n++) line[n] <= line[n-1];
                end
            end
            assign a_edge[i] = line[i-1];
        end
    end

    // B skew: column j passes through j registers.
    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        logic signed [DW-1:0] b_src;
        assign b_src = (state == ST_FEED) ? $signed(b_data[j*DW +: DW]) : '0;
        if (j == 0) begin : g_direct
            assign b_edge[j] = b_src;
        end else begin : g_line
            logic signed [DW-1:0] line [j];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int n = 0; n < j; n++) line[n] <= '0;
                end else if (clr) begin
                    for (int n = 0; n < j; n++) line[n] <= '0;
                end else if (adv) begin
                    line[0] <= b_src;
                    for (int n = 1; n < j; n++) line[n] <= line[n-1];
                end
            end
            assign b_edge[j] = line[j-1];
        end
    end

    // PE grid: A flows right, B flows down.
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic signed [DW-1:0] a_in;
            logic signed [DW-1:0] b_in;
            if (j == 0) begin : g_a_left
                assign a_in = a_edge[i];
            end else begin : g_a_chain
                assign a_in = a_fw[i][j-1];
            end
            if (i == 0) begin : g_b_top
                assign b_in = b_edge[j];
            end else begin : g_b_chain
                assign b_in = b_fw[i-1][j];
            end
            sa_pe #(.DW(DW), .AW(AW)) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr),
                .adv   (adv),
                .a_in  (a_in),
                .b_in  (b_in),
                .a_out (a_fw[i][j]),
                .b_out (b_fw[i][j]),
                .acc   (accs[i][j])
            );
        end
    end

    // Row of accumulators to load into c_data: row 0 on entering DRAIN, next row on a beat.
    always_comb begin
        load_row = (state == ST_DRAIN) ? RW'(c_row + RW'(1)) : '0;
        row_vec  = '0;
        for (int j = 0; j < COLS; j++) begin
            row_vec[j*AW +: AW] = accs[load_row][j];
        end
    end

    // Control FSM with registered outputs.
    // FLUSH runs one cycle longer than the skew depth needs, so on its last
    // cycle the accumulators are already final and can be captured directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            k_reg     <= '0;
            fire_cnt  <= '0;
            flush_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            a_ready   <= 1'b0;
            b_ready   <= 1'b0;
            c_valid   <= 1'b0;
            c_data    <= '0;
            c_row     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        k_reg     <= k_len;
                        fire_cnt  <= '0;
                        flush_cnt <= '0;
                        busy      <= 1'b1;
                        if (k_len == 16'd0) begin
                            state   <= ST_DRAIN;
                            c_valid <= 1'b1;
                            c_row   <= '0;
                            c_data  <= '0;
                        end else begin
                            state   <= ST_FEED;
                            a_ready <= 1'b1;
                            b_ready <= 1'b1;
                        end
                    end
                end
                ST_FEED: begin
                    if (fire) begin
                        fire_cnt <= fire_cnt + 16'd1;
                        if (fire_cnt == k_reg - 16'd1) begin
                            state   <= ST_FLUSH;
                            a_ready <= 1'b0;
                            b_ready <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    flush_cnt <= flush_cnt + FW'(1);
                    if (flush_cnt == FW'(FLUSH_LEN - 1)) begin
                        state   <= ST_DRAIN;
                        c_valid <= 1'b1;
                        c_row   <= '0;
                        c_data  <= row_vec;
                    end
                end
                ST_DRAIN: begin
                    if (c_ready) begin
                        if (c_row == RW'(ROWS - 1)) begin
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            c_valid <= 1'b0;
                            c_row   <= '0;
                            c_data  <= '0;
                        end else begin
                            c_row  <= c_row + RW'(1);
                            c_data <= row_vec;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sa_matmul_engine.md
SA_MATMUL_ENGINE -- requirements
Module: sa_matmul_engine

Interface
REQ-001 SHALL have parameter DW, default 16: signed operand width.
REQ-002 SHALL have parameter AW, default 40: signed accumulator/result width, AW >= 2*DW.
REQ-003 SHALL have parameters ROWS, default 4, and COLS, default 4: array dimensions, each 2..16.
REQ-004 SHALL have port clk  in  1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have ports start  in  1 and k_len  in  16: job start; inner dimension K, sampled on accepted start.
REQ-007 SHALL have ports busy  out  1 and done  out  1: job in progress; one-cycle pulse after last result beat.
REQ-008 SHALL have ports a_valid  in  1, a_ready  out  1, a_data  in  ROWS*DW: A column k, row i in bits [i*DW +: DW].
REQ-009 SHALL have ports b_valid  in  1, b_ready  out  1, b_data  in  COLS*DW: B row k, column j in bits [j*DW +: DW].
REQ-010 SHALL have ports c_valid  out  1, c_ready  in  1, c_data  out  COLS*AW, c_row  out  clog2(ROWS): one row of C per beat.

Function
REQ-011 SHALL compute C[i][j] = sum over k of A[i][k]*B[k][j], output-stationary, one accumulator per PE.
REQ-012 SHALL implement FSM IDLE -> FEED -> FLUSH -> DRAIN -> IDLE.
REQ-013 SHALL accept start only in IDLE; on acceptance clear all accumulators and skew registers, latch k_len, assert busy next cycle. Start while busy SHALL be ignored.
REQ-014 SHALL assert a_ready = b_ready = 1 only in FEED. A beat fires only when a_valid & b_valid & state==FEED. Operands are consumed jointly; a lone valid consumes nothing.
REQ-015 SHALL advance the array (skew lines, PE pipelines, MACs) only on a fire in FEED or on every FLUSH cycle. Otherwise all array state holds.
REQ-016 SHALL skew inputs: row i of A delayed i advances; column j of B delayed j advances. A propagates right and B propagates down, one PE per advance.
REQ-017 SHALL leave FEED after the k_len-th fire. FLUSH SHALL inject zeros for exactly ROWS+COLS-1 cycles.
REQ-018 SHALL, with k_len==0, go from IDLE directly to DRAIN and output all-zero rows.
REQ-019 SHALL, in DRAIN, present rows 0..ROWS-1 in order. c_valid is high throughout DRAIN. c_data/c_row hold stable while c_valid & ~c_ready. The row index advances on c_valid & c_ready.
REQ-020 SHALL pulse done and return to IDLE on the cycle after the row ROWS-1 handshake. busy drops in the same cycle.
REQ-021 SHALL sign-extend products to AW. Default accumulation wraps modulo 2^AW.

Reset
REQ-022 SHALL, on rst_n low (any state, including mid-FEED or mid-DRAIN), immediately force IDLE and clear all accumulators, skew/pipeline registers and the row counter. All outputs are 0: busy, done, a_ready, b_ready, c_valid, c_data, c_row.
REQ-023 SHALL require a new start after reset release; a partial job SHALL NOT resume.

Configuration
REQ-024 SHALL, with SA_SATURATE_EN defined, saturate each accumulation to [-2^(AW-1), 2^(AW-1)-1]. Without it, accumulation wraps per REQ-021. The interface is identical either way.

Structure
REQ-025 SHALL place the FSM state enum, the FEED/FLUSH/DRAIN encodings and the saturation helper function in package sa_pkg.
REQ-026 SHALL instantiate a ROWS x COLS grid of sub-module sa_pe: MAC plus A/B forwarding registers, advance enable, synchronous clear.

Verification
REQ-027 SHALL cover: 4x4, K=4, A=identity, B=1..16 row-major -> C rows equal B rows; c_row 0..3; done one cycle after last beat.
REQ-028 SHALL cover: k_len=0 -> DRAIN right after start, four rows all zero, no a_ready/b_ready ever high.
REQ-029 SHALL cover: K=8 random data, a_valid and b_valid toggled independently at random -> C matches reference model; no beat lost or duplicated.
REQ-030 SHALL cover: c_ready held low 5 cycles per row -> c_data/c_row stable while stalled; rows in order.
REQ-031 SHALL cover: DW=16, AW=32, K=3, all A=B=-32768 -> sum 3*2^30: wraps to -1073741824 without SA_SATURATE_EN, equals 2147483647 with it.
REQ-032 SHALL cover: rst_n low mid-FEED after 2 of 4 beats -> outputs 0 at once; a new job with identity data gives a correct result.
